// File: rtl/csr_initiator_if.sv
// Command/response channel and CSR strobe bus used by csr_initiator.
// The command source drives "master" on csr_cmd_if; the initiator drives "master" on csr_bus_if.
interface csr_cmd_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cmd_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_timeout;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, rsp_err
  );
endinterface

interface csr_bus_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output wr_en, rd_en, addr, wdata, input rdata);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/csr_initiator.sv
// CSR bus master: turns WRITE/READ/POLL commands into single-cycle CSR strobes
// and returns one registered response per command.
//
// state     | meaning
// S_IDLE    | cmd_ready=1, waiting for a command
// S_WRITE   | csr wr_en strobe cycle
// S_READ    | csr rd_en strobe cycle, rdata captured at its end
// S_POLL_RD | poll read strobe, compare under mask, count reads
// S_POLL_WAIT | idle gap between poll reads
// S_RSP     | response held until rsp_ready
module csr_initiator #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32,
  parameter int POLL_GAP  = 4,
  parameter int MAX_POLLS = 256
) (
  input  logic      clk,
  input  logic      rst_n,
  csr_cmd_if.slave  cmd,
  csr_bus_if.master csr,
  output logic      busy_o
);

  localparam int CNT_W = $clog2(MAX_POLLS + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_POLLS);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_POLL_RD, S_POLL_WAIT, S_RSP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      rdata_q    <= '0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
      poll_cnt_q <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      poll_cnt_q <= poll_cnt_d;
      gap_q      <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    rdata_d    = rdata_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    poll_cnt_d = poll_cnt_q;
    gap_d      = gap_q;
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          addr_d     = cmd.cmd_addr;
          wdata_d    = cmd.cmd_wdata;
          mask_d     = cmd.cmd_mask;
          rdata_d    = '0;
          timeout_d  = 1'b0;
          err_d      = 1'b0;
          poll_cnt_d = '0;
          case (cmd.cmd_op)
            2'b00:   state_d = S_WRITE;
            2'b01:   state_d = S_READ;
            2'b10:   state_d = S_POLL_RD;
            default: begin
              err_d   = 1'b1;
              state_d = S_RSP;
            end
          endcase
        end
      end
      S_WRITE: state_d = S_RSP;
      S_READ: begin
        rdata_d = csr.rdata;
        state_d = S_RSP;
      end
      S_POLL_RD: begin
        rdata_d    = csr.rdata;
        poll_cnt_d = poll_cnt_q + CNT_W'(1);
        if ((csr.rdata & mask_q) == (wdata_q & mask_q)) begin
          state_d = S_RSP;
        end else if (poll_cnt_d == MAX_CNT) begin
          timeout_d = 1'b1;
          state_d   = S_RSP;
        end else if (POLL_GAP == 0) begin
          state_d = S_POLL_RD;
        end else begin
          gap_d   = GAP_LOAD;
          state_d = S_POLL_WAIT;
        end
      end
      // Down-counter loaded with GAP-1 so the state lasts exactly POLL_GAP cycles.
      S_POLL_WAIT: begin
        if (gap_q == '0) state_d = S_POLL_RD;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      S_RSP: begin
        if (cmd.rsp_ready) begin
          timeout_d = 1'b0;
          err_d     = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd.cmd_ready   = (state_q == S_IDLE);
  assign cmd.rsp_valid   = (state_q == S_RSP);
  assign cmd.rsp_rdata   = rdata_q;
  assign cmd.rsp_timeout = timeout_q;
  assign cmd.rsp_err     = err_q;
  assign busy_o          = (state_q != S_IDLE);

  assign csr.wr_en = (state_q == S_WRITE);
  assign csr.rd_en = (state_q == S_READ) || (state_q == S_POLL_RD);
  assign csr.addr  = addr_q;
  assign csr.wdata = wdata_q;

endmodule

// File: tb/tb_csr_initiator.sv
// Directed bench for csr_initiator (POLL_GAP=4, MAX_POLLS=4) with a small CSR
// register model; address 0x8 reads back snapshot_done in bit 0.
module tb_csr_initiator;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic snap;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int   wr_tot = 0, rd_tot = 0, both_tot = 0;
  int   rd_log [128];
  logic [31:0] regs [16];

  csr_cmd_if #(.ADDR_W(4), .DATA_W(32)) cmd_if ();
  csr_bus_if #(.ADDR_W(4), .DATA_W(32)) bus_if ();

  csr_initiator #(.ADDR_W(4), .DATA_W(32), .POLL_GAP(4), .MAX_POLLS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd    (cmd_if),
    .csr    (bus_if),
    .busy_o (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus_if.wr_en && bus_if.addr != 4'h8) regs[bus_if.addr] <= bus_if.wdata;
  assign bus_if.rdata = (bus_if.addr == 4'h8) ? {31'b0, snap} : regs[bus_if.addr];

  always @(negedge clk) begin
    if (bus_if.wr_en) wr_tot++;
    if (bus_if.rd_en) begin
      if (rd_tot < 128) rd_log[rd_tot] = cyc;
      rd_tot++;
    end
    if (bus_if.wr_en && bus_if.rd_en) both_tot++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns acc = edge count at which the command is accepted; exits on the negedge after it.
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [31:0] wd,
                      input logic [31:0] mk, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_addr  = a;
    cmd_if.cmd_wdata = wd;
    cmd_if.cmd_mask  = mk;
    while (!cmd_if.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_bound", 32'(n), 32'd0);
    acc = cyc + 1;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'($urandom);
    cmd_if.cmd_addr  = 4'($urandom);
    cmd_if.cmd_wdata = $urandom;
    cmd_if.cmd_mask  = $urandom;
  endtask

  task automatic wait_rsp(output int rc, output logic [31:0] rd, output logic to, output logic er);
    int n;
    n = 0;
    while (!cmd_if.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("rsp_bound", 32'(n), 32'd0);
    rc = cyc;
    rd = cmd_if.rsp_rdata;
    to = cmd_if.rsp_timeout;
    er = cmd_if.rsp_err;
    @(negedge clk);
  endtask

  initial begin
    int acc, rc, wb, rb;
    logic [31:0] rd;
    logic to, er;

    rst_n = 1'b0;
    snap  = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_addr  = '0;
    cmd_if.cmd_wdata = '0;
    cmd_if.cmd_mask  = '0;
    cmd_if.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", {30'b0, bus_if.wr_en, bus_if.rd_en}, 32'd0);
    chk("rst_rdata", cmd_if.rsp_rdata, 32'd0);
    chk("rst_addr", 32'(bus_if.addr), 32'd0);

    // 1: WRITE 0x4 <- 100, READ back
    wb = wr_tot; rb = rd_tot;
    send(2'b00, 4'h4, 32'd100, 32'h0, acc);
    wait_rsp(rc, rd, to, er);
    chk("wr_lat", 32'(rc), 32'(acc + 1));
    chk("wr_cnt", 32'(wr_tot - wb), 32'd1);
    chk("wr_rd_cnt", 32'(rd_tot - rb), 32'd0);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_flags", {30'b0, to, er}, 32'd0);
    chk("wr_addr_hold", 32'(bus_if.addr), 32'h4);
    chk("wr_wdata_hold", bus_if.wdata, 32'd100);

    wb = wr_tot; rb = rd_tot;
    send(2'b01, 4'h4, 32'h0, 32'h0, acc);
    wait_rsp(rc, rd, to, er);
    chk("rd_lat", 32'(rc), 32'(acc + 1));
    chk("rd_strobe_cyc", 32'(rd_log[rb]), 32'(acc));
    chk("rd_cnt", 32'(rd_tot - rb), 32'd1);
    chk("rd_wr_cnt", 32'(wr_tot - wb), 32'd0);
    chk("rd_rdata", rd, 32'd100);
    chk("rd_flags", {30'b0, to, er}, 32'd0);

    // 2: POLL matches on the third read
    snap = 1'b0;
    rb = rd_tot;
    send(2'b10, 4'h8, 32'h1, 32'h1, acc);
    repeat (9) @(negedge clk);
    snap = 1'b1;
    wait_rsp(rc, rd, to, er);
    chk("poll_cnt", 32'(rd_tot - rb), 32'd3);
    chk("poll_first", 32'(rd_log[rb]), 32'(acc));
    chk("poll_gap1", 32'(rd_log[rb + 1] - rd_log[rb]), 32'd5);
    chk("poll_gap2", 32'(rd_log[rb + 2] - rd_log[rb + 1]), 32'd5);
    chk("poll_lat", 32'(rc), 32'(rd_log[rb + 2] + 1));
    chk("poll_rdata", rd, 32'd1);
    chk("poll_flags", {30'b0, to, er}, 32'd0);

    // 3: POLL never matches -> MAX_POLLS reads then timeout
    snap = 1'b0;
    rb = rd_tot;
    send(2'b10, 4'h8, 32'h1, 32'h1, acc);
    wait_rsp(rc, rd, to, er);
    chk("to_cnt", 32'(rd_tot - rb), 32'd4);
    chk("to_span", 32'(rd_log[rb + 3] - rd_log[rb]), 32'd15);
    chk("to_lat", 32'(rc), 32'(acc + 16));
    chk("to_timeout", 32'(to), 32'd1);
    chk("to_err", 32'(er), 32'd0);
    chk("to_rdata", rd, 32'd0);

    // mask=0 matches on the first read
    rb = rd_tot;
    send(2'b10, 4'h8, 32'h5, 32'h0, acc);
    wait_rsp(rc, rd, to, er);
    chk("mask0_cnt", 32'(rd_tot - rb), 32'd1);
    chk("mask0_lat", 32'(rc), 32'(acc + 1));
    chk("mask0_timeout", 32'(to), 32'd0);

    // 4: response backpressure
    send(2'b00, 4'h0, 32'hDEAD_BEEF, 32'h0, acc);
    wait_rsp(rc, rd, to, er);
    cmd_if.rsp_ready = 1'b0;
    wb = wr_tot; rb = rd_tot;
    send(2'b01, 4'h0, 32'h0, 32'h0, acc);
    wait_rsp(rc, rd, to, er);
    chk("bp_rdata", rd, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(cmd_if.rsp_valid), 32'd1);
      chk("bp_hold", cmd_if.rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp_rd_cnt", 32'(rd_tot - rb), 32'd1);
    chk("bp_wr_cnt", 32'(wr_tot - wb), 32'd0);
    cmd_if.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(cmd_if.rsp_valid), 32'd0);
    chk("bp_release_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // 5: illegal opcode, then a WRITE still works
    wb = wr_tot; rb = rd_tot;
    send(2'b11, 4'h2, 32'h0, 32'h0, acc);
    wait_rsp(rc, rd, to, er);
    chk("err_lat", 32'(rc), 32'(acc));
    chk("err_flag", 32'(er), 32'd1);
    chk("err_timeout", 32'(to), 32'd0);
    chk("err_strobes", 32'((wr_tot - wb) + (rd_tot - rb)), 32'd0);
    chk("err_clear", 32'(cmd_if.rsp_err), 32'd0);
    wb = wr_tot;
    send(2'b00, 4'h2, 32'h55, 32'h0, acc);
    wait_rsp(rc, rd, to, er);
    chk("err_next_wr", 32'(wr_tot - wb), 32'd1);
    chk("err_next_flags", {30'b0, to, er}, 32'd0);
    send(2'b01, 4'h2, 32'h0, 32'h0, acc);
    wait_rsp(rc, rd, to, er);
    chk("err_next_rd", rd, 32'h55);

    // 6: async reset during POLL_WAIT
    snap = 1'b0;
    send(2'b10, 4'h8, 32'h1, 32'h1, acc);
    repeat (2) @(negedge clk);
    chk("rst6_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst6_rd_en", 32'(bus_if.rd_en), 32'd0);
    chk("rst6_rsp_valid", 32'(cmd_if.rsp_valid), 32'd0);
    chk("rst6_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rb = rd_tot;
    send(2'b01, 4'h4, 32'h0, 32'h0, acc);
    wait_rsp(rc, rd, to, er);
    chk("rst6_read", rd, 32'd100);
    chk("rst6_rd_cnt", 32'(rd_tot - rb), 32'd1);
    chk("rst6_lat", 32'(rc), 32'(acc + 1));

    chk("strobe_overlap", 32'(both_tot), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
